cavlc_blk_end_ctrl: RTL and testbench
=====================================

# cavlc_blk_end_ctrl

Sequential, parametrised end-of-block controller for the CAVLC residual path. It sits beside the CAVLC decoder state machine and tracks the nonzero coefficients still to be decoded in the current block. It emits a registered end-of-block pulse and keeps per-channel DC-all-zero flags for the current macroblock, one channel per colour component in 4:4:4 mode.

## Interface
Parameters:
- MAX_COEFF, 16: maximum coefficients per block (16 for 4x4 luma, 4 for 4:2:0 chroma DC).
- NUM_CH, 3: tracked channels (0 = Y, 1 = Cb, 2 = Cr).
- CNT_W, 5: width of the coefficient counter; must hold MAX_COEFF.
- CH_W, 2: width of the channel index; 2^CH_W >= NUM_CH.

Ports:
- clk, input, 1: the only clock; everything is rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- mb_start, input, 1: one-cycle pulse at macroblock start; re-arms the DC flags.
- blk_start, input, 1: one-cycle pulse when the decoder finishes coeff_token for a block.
- total_coeff, input, CNT_W: TotalCoeff of the block; sampled on blk_start.
- ch_idx, input, CH_W: channel of the block; sampled on blk_start.
- is_dc, input, 1: the block is a DC block; sampled on blk_start.
- level_valid, input, 1: one level/run pair was decoded (LevelRunCombination step) this cycle.
- err_clear, input, 1: clears err.
- end_of_blk, output, 1: registered one-cycle end-of-block pulse.
- busy, output, 1: a block with remaining coefficients is in progress.
- coeff_remaining, output, CNT_W: coefficients still expected.
- dc_all_zero, output, NUM_CH: bit c = 1 means no DC block of channel c has had a nonzero TotalCoeff since the last mb_start.
- err, output, 1: sticky protocol-error flag.

## Operation
State machine with three states: IDLE, COUNT, DONE.
- IDLE, blk_start with total_coeff = 0: go to DONE.
- IDLE, blk_start with total_coeff > 0: go to COUNT; coeff_remaining <= min(total_coeff, MAX_COEFF).
- COUNT, level_valid: coeff_remaining decrements by 1. When it was 1, go to DONE.
- DONE: end_of_blk = 1 for this one cycle, then go to IDLE.
- DONE, blk_start: handled exactly as in IDLE, so back-to-back blocks lose no cycle.

DC flags:
- mb_start sets all dc_all_zero bits to 1.
- blk_start with is_dc = 1, total_coeff > 0 and ch_idx < NUM_CH clears bit ch_idx.
- If mb_start and a clearing blk_start arrive in the same cycle, the clear wins for that bit; all other bits are set.

Error conditions: each sets err = 1 and the offending event has no other effect, except where stated.
- blk_start while in COUNT.
- level_valid while in IDLE or DONE.
- total_coeff > MAX_COEFF. The block still proceeds with the value clamped to MAX_COEFF.
- ch_idx >= NUM_CH. Counting still proceeds, but no flag changes.

err stays set until err_clear is asserted. If an error event and err_clear occur in the same cycle, err = 1 (set wins).

Arithmetic: the counter is unsigned CNT_W bits and never wraps. It cannot decrement below 0 because level_valid is only honoured in COUNT.

## Timing
- Reset values: state IDLE, end_of_blk 0, busy 0, coeff_remaining 0, dc_all_zero all 1, err 0.
- Reset asserted mid-block aborts the block immediately. No end_of_blk is produced.
- blk_start at cycle t with total_coeff = 0: end_of_blk = 1 at t+1.
- Last honoured level_valid at cycle u: end_of_blk = 1 at u+1, and busy = 0 from u+1.
- busy = 1 exactly while in COUNT.
- coeff_remaining reflects the value after the edge of cycle t (registered).
- Minimum block period is 2 cycles (blk_start, then DONE).
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Reset, then blk_start with total_coeff = 0, ch 0, is_dc = 1 -> end_of_blk at the next cycle, dc_all_zero = 3'b111, err = 0.
- blk_start with total_coeff = 3, then level_valid on 3 consecutive cycles -> coeff_remaining 3, 2, 1, 0, busy high for 3 cycles, single end_of_blk the cycle after the third level_valid.
- Back-to-back: blk_start with total_coeff = 1, then level_valid, then blk_start in the DONE cycle with total_coeff = 2 -> one end_of_blk pulse, busy again the next cycle, coeff_remaining = 2.
- mb_start, then DC block on ch 2 with total_coeff = 4 -> dc_all_zero = 3'b011. Then mb_start in the same cycle as a DC blk_start on ch 1 with total_coeff = 1 -> dc_all_zero = 3'b101.
- Errors: level_valid in IDLE -> err = 1 and counter unchanged. total_coeff = 20 with MAX_COEFF = 16 -> err = 1 and coeff_remaining = 16. err_clear -> err = 0.
- Reset asserted with coeff_remaining = 5 -> all outputs return to their reset values asynchronously, and no end_of_blk follows.

Source files
------------

// File: rtl/cavlc_blk_end_ctrl_if.sv
// Block-level control/status bundle between the CAVLC decoder FSM and the end-of-block controller.
// The decoder side is the master; the controller answers with registered status only.
interface cavlc_blk_end_ctrl_if #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 5,
   parameter int CH_W   = 2
);
   logic              mb_start;
   logic              blk_start;
   logic [CNT_W-1:0]  total_coeff;
   logic [CH_W-1:0]   ch_idx;
   logic              is_dc;
   logic              level_valid;
   logic              err_clear;
   logic              end_of_blk;
   logic              busy;
   logic [CNT_W-1:0]  coeff_remaining;
   logic [NUM_CH-1:0] dc_all_zero;
   logic              err;

   modport master (
      output mb_start, blk_start, total_coeff, ch_idx, is_dc, level_valid, err_clear,
      input  end_of_blk, busy, coeff_remaining, dc_all_zero, err
   );

   modport slave (
      input  mb_start, blk_start, total_coeff, ch_idx, is_dc, level_valid, err_clear,
      output end_of_blk, busy, coeff_remaining, dc_all_zero, err
   );
endinterface

// File: rtl/cavlc_blk_end_ctrl.sv
// Counts down a block's TotalCoeff on level/run steps and pulses end_of_blk one cycle after the last one;
// all outputs registered (1-cycle latency), no backpressure: protocol violations only raise the sticky err.
module cavlc_blk_end_ctrl #(
   parameter int MAX_COEFF = 16,
   parameter int NUM_CH    = 3,
   parameter int CNT_W     = 5,
   parameter int CH_W      = 2
) (
   input logic              clk,
   input logic              reset,
   cavlc_blk_end_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COEFF);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NUM_CH-1:0] dc_q, dc_d;
   logic              err_q, err_d;

   logic              accept_blk;
   logic              blk_bad;
   logic              lv_bad;
   logic              tc_over;
   logic              ch_bad;
   logic [CNT_W-1:0]  tc_clamped;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dc_q    <= '1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dc_q    <= dc_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dc_d       = bus.mb_start ? {NUM_CH{1'b1}} : dc_q;
      err_d      = bus.err_clear ? 1'b0 : err_q;

      // DONE accepts a new block exactly like IDLE so back-to-back blocks lose no cycle
      accept_blk = bus.blk_start && (state_q != COUNT);
      blk_bad    = bus.blk_start && (state_q == COUNT);
      lv_bad     = bus.level_valid && (state_q != COUNT);
      tc_over    = accept_blk && (bus.total_coeff > MAX_C);
      ch_bad     = accept_blk && (int'(bus.ch_idx) >= NUM_CH);
      tc_clamped = tc_over ? MAX_C : bus.total_coeff;

      case (state_q)
         COUNT: begin
            if (bus.level_valid) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            if (accept_blk) begin
               cnt_d   = tc_clamped;
               state_d = (tc_clamped == '0) ? DONE : COUNT;
            end
         end
      endcase

      // A clearing DC block overrides a simultaneous mb_start re-arm for its own channel only
      for (int c = 0; c < NUM_CH; c++) begin
         if (accept_blk && bus.is_dc && (bus.total_coeff != '0) && (int'(bus.ch_idx) == c)) begin
            dc_d[c] = 1'b0;
         end
      end

      if (blk_bad || lv_bad || tc_over || ch_bad) begin
         err_d = 1'b1;
      end
   end

   assign bus.end_of_blk      = (state_q == DONE);
   assign bus.busy            = (state_q == COUNT);
   assign bus.coeff_remaining = cnt_q;
   assign bus.dc_all_zero     = dc_q;
   assign bus.err             = err_q;

endmodule

// File: tb/tb_cavlc_blk_end_ctrl.sv
// Directed bench for cavlc_blk_end_ctrl: each stimulus cycle queues its expected post-edge outputs,
// and a monitor pops and compares them one cycle-edge later.
module tb_cavlc_blk_end_ctrl;

   typedef struct {
      int         id;
      logic       eob;
      logic       busy;
      logic [4:0] cnt;
      logic [2:0] dc;
      logic       err;
   } exp_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_bad;
   int   vec_id;
   exp_t exp_q[$];

   cavlc_blk_end_ctrl_if bus_if ();

   cavlc_blk_end_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare_vec(input exp_t e);
      n_vec++;
      if (bus_if.end_of_blk !== e.eob || bus_if.busy !== e.busy ||
          bus_if.coeff_remaining !== e.cnt || bus_if.dc_all_zero !== e.dc || bus_if.err !== e.err) begin
         n_bad++;
         $display("FAIL vec%0d: got eob=%b busy=%b cnt=%0d dc=%b err=%b, want eob=%b busy=%b cnt=%0d dc=%b err=%b",
                  e.id, bus_if.end_of_blk, bus_if.busy, bus_if.coeff_remaining, bus_if.dc_all_zero, bus_if.err,
                  e.eob, e.busy, e.cnt, e.dc, e.err);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the following rising edge
   task automatic step(input logic mb, input logic bs, input int tc, input int ch, input logic dc_blk,
                       input logic lv, input logic ec,
                       input logic x_eob, input logic x_busy, input int x_cnt, input logic [2:0] x_dc,
                       input logic x_err);
      exp_t e;
      @(negedge clk);
      bus_if.mb_start    = mb;
      bus_if.blk_start   = bs;
      bus_if.total_coeff = 5'(tc);
      bus_if.ch_idx      = 2'(ch);
      bus_if.is_dc       = dc_blk;
      bus_if.level_valid = lv;
      bus_if.err_clear   = ec;
      e.id   = vec_id++;
      e.eob  = x_eob;
      e.busy = x_busy;
      e.cnt  = 5'(x_cnt);
      e.dc   = x_dc;
      e.err  = x_err;
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compare_vec(e);
         end
      end
   end

   initial begin
      exp_t r;
      n_vec  = 0;
      n_bad  = 0;
      vec_id = 0;
      reset  = 1'b1;
      bus_if.mb_start    = 1'b0;
      bus_if.blk_start   = 1'b0;
      bus_if.total_coeff = '0;
      bus_if.ch_idx      = '0;
      bus_if.is_dc       = 1'b0;
      bus_if.level_valid = 1'b0;
      bus_if.err_clear   = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      //    mb bs tc ch dc lv ec   eob busy cnt dc      err
      step(0, 0, 0, 0, 0, 0, 0,   0,  0,   0, 3'b111, 0);   // reset state
      step(0, 1, 0, 0, 1, 0, 0,   1,  0,   0, 3'b111, 0);   // empty block -> immediate eob
      step(0, 0, 0, 0, 0, 0, 0,   0,  0,   0, 3'b111, 0);
      step(0, 1, 3, 0, 0, 0, 0,   0,  1,   3, 3'b111, 0);   // 3-coeff block
      step(0, 0, 0, 0, 0, 1, 0,   0,  1,   2, 3'b111, 0);
      step(0, 0, 0, 0, 0, 1, 0,   0,  1,   1, 3'b111, 0);
      step(0, 0, 0, 0, 0, 1, 0,   1,  0,   0, 3'b111, 0);
      step(0, 0, 0, 0, 0, 0, 0,   0,  0,   0, 3'b111, 0);
      step(0, 1, 1, 0, 0, 0, 0,   0,  1,   1, 3'b111, 0);   // back-to-back, non-DC keeps flag
      step(0, 0, 0, 0, 0, 1, 0,   1,  0,   0, 3'b111, 0);
      step(0, 1, 2, 0, 0, 0, 0,   0,  1,   2, 3'b111, 0);   // blk_start in DONE
      step(0, 0, 0, 0, 0, 1, 0,   0,  1,   1, 3'b111, 0);
      step(0, 0, 0, 0, 0, 1, 0,   1,  0,   0, 3'b111, 0);
      step(0, 0, 0, 0, 0, 0, 0,   0,  0,   0, 3'b111, 0);
      step(1, 0, 0, 0, 0, 0, 0,   0,  0,   0, 3'b111, 0);   // mb_start
      step(0, 1, 4, 2, 1, 0, 0,   0,  1,   4, 3'b011, 0);   // DC on Cr clears bit 2
      for (int i = 3; i >= 1; i--)
         step(0, 0, 0, 0, 0, 1, 0, 0, 1, i, 3'b011, 0);
      step(0, 0, 0, 0, 0, 1, 0,   1,  0,   0, 3'b011, 0);
      step(1, 1, 1, 1, 1, 0, 0,   0,  1,   1, 3'b101, 0);   // mb_start + clearing DC on Cb
      step(0, 0, 0, 0, 0, 1, 0,   1,  0,   0, 3'b101, 0);
      step(0, 0, 0, 0, 0, 0, 0,   0,  0,   0, 3'b101, 0);
      step(0, 0, 0, 0, 0, 1, 0,   0,  0,   0, 3'b101, 1);   // level_valid in IDLE
      step(0, 0, 0, 0, 0, 0, 1,   0,  0,   0, 3'b101, 0);   // err_clear
      step(0, 1, 20, 0, 0, 0, 0,  0,  1,  16, 3'b101, 1);   // oversized TotalCoeff clamps
      step(0, 1, 3, 0, 1, 0, 1,   0,  1,  16, 3'b101, 1);   // blk_start in COUNT, set beats clear
      step(0, 0, 0, 0, 0, 0, 1,   0,  1,  16, 3'b101, 0);
      for (int i = 15; i >= 5; i--)
         step(0, 0, 0, 0, 0, 1, 0, 0, 1, i, 3'b101, 0);

      // Asynchronous reset mid-block with 5 coefficients outstanding
      @(negedge clk);
      bus_if.level_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      r.id = vec_id++; r.eob = 1'b0; r.busy = 1'b0; r.cnt = 5'd0; r.dc = 3'b111; r.err = 1'b0;
      compare_vec(r);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0);     // no eob after abort

      step(0, 1, 2, 3, 1, 0, 0,   0,  1,   2, 3'b111, 1);   // bad channel: counts, no flag change
      step(0, 0, 0, 0, 0, 1, 0,   0,  1,   1, 3'b111, 1);
      step(0, 0, 0, 0, 0, 1, 0,   1,  0,   0, 3'b111, 1);
      step(0, 0, 0, 0, 0, 0, 1,   0,  0,   0, 3'b111, 0);

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
